redmule_z_drain: RTL and testbench

REDMULE_Z_DRAIN -- requirements
Module: redmule_z_drain

---
 rtl/redmule_pkg.sv | 51 +++++
 rtl/redmule_z_drain_scm.sv | 47 ++++
 rtl/redmule_z_drain.sv | 144 ++++++++++++++
 tb/tb_redmule_z_drain.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : redmule_pkg
//  Description : Shared types and constants for the RedMulE Z drain buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package redmule_pkg;

    // Number of result rows produced by the array per tile.
    localparam int unsigned ARRAY_WIDTH = 4;

    // Floating-point formats understood by the datapath.
    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    // Bit width of one element of the given format.
    function automatic int unsigned fp_width(input fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP8:     return 8;
            default: return 16;
        endcase
    endfunction

    // Occupancy state of one ping-pong bank.
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // Tile geometry: valid columns (1..D) and valid rows (1..W).
    typedef struct packed {
        logic [7:0] width;
        logic [7:0] height;
    } z_drain_ctrl_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic bank_done;
    } z_drain_flgs_t;

endpackage
`default_nettype wire

// File: rtl/redmule_z_drain_scm.sv
`default_nettype none
// ============================================================================
//  Module      : redmule_z_drain_scm
//  Description : Two-bank element storage; column write, row read per bank.
//                Storage is intentionally not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module redmule_z_drain_scm #(
    parameter int unsigned BITW  = 16,
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 18,
    parameter int unsigned COLW  = 5,
    parameter int unsigned ROWW  = 2
) (
    input  logic                                clk_i,
    input  logic [1:0]                          we_i,
    input  logic [COLW-1:0]                     wcol_i,
    input  logic [ROWS-1:0][BITW-1:0]           wdata_i,
    input  logic [ROWW-1:0]                     rrow_i,
    output logic [1:0][COLS-1:0][BITW-1:0]      rdata_o
);

    logic [BITW-1:0] r_mem [2][ROWS][COLS];

    // Column write: every row of the selected column of each enabled bank.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 2; b++) begin
            if (we_i[b]) begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    r_mem[b][r][wcol_i] <= wdata_i[r];
                end
            end
        end
    end

    // Row read: the addressed row of both banks, selected by the caller.
    always_comb begin
        rdata_o = '0;
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                rdata_o[b][c] = r_mem[b][rrow_i][c];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/redmule_z_drain.sv
`default_nettype none
// ============================================================================
//  Module      : redmule_z_drain
//  Description : Ping-pong transpose buffer: accepts result columns from the
//                array and streams out tile rows with byte enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module redmule_z_drain
    import redmule_pkg::*;
#(
    parameter int unsigned DW       = 288,
    parameter fp_format_e  FpFormat = FP16,
    parameter int unsigned Width    = ARRAY_WIDTH
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      clear_i,
    input  z_drain_ctrl_t                             ctrl_i,
    output z_drain_flgs_t                             flags_o,
    input  logic [Width-1:0][fp_width(FpFormat)-1:0]  z_i,
    input  logic                                      z_valid_i,
    output logic                                      z_ready_o,
    output logic [DW-1:0]                             z_o,
    output logic [DW/8-1:0]                           z_strb_o,
    output logic                                      z_valid_o,
    input  logic                                      z_ready_i
);

    localparam int unsigned c_BITW  = fp_width(FpFormat);
    localparam int unsigned c_D     = DW / c_BITW;
    localparam int unsigned c_COLW  = (c_D > 1) ? $clog2(c_D) : 1;
    localparam int unsigned c_ROWW  = (Width > 1) ? $clog2(Width) : 1;
    localparam int unsigned c_NBYTE = DW / 8;

    bank_state_e              r_state   [2];
    bank_state_e              w_state_nxt [2];
    logic                     r_wb;
    logic                     r_rb;
    logic [c_COLW-1:0]        r_col;
    logic [c_ROWW-1:0]        r_row;
    logic                     r_bank_done;

    logic                     w_wr_hs;
    logic                     w_rd_hs;
    logic                     w_col_last;
    logic                     w_row_last;
    logic [1:0]               w_we;
    logic [1:0][c_D-1:0][c_BITW-1:0] w_rdata;

    // The write bank accepts columns until it is FULL; the read bank is
    // presented only when FULL, so the two never touch the same bank.
    assign z_ready_o  = (r_state[r_wb] != BANK_FULL);
    assign z_valid_o  = (r_state[r_rb] == BANK_FULL);
    assign w_wr_hs    = z_valid_i & z_ready_o;
    assign w_rd_hs    = z_valid_o & z_ready_i;
    assign w_col_last = (8'(r_col) == (ctrl_i.width  - 8'd1));
    assign w_row_last = (8'(r_row) == (ctrl_i.height - 8'd1));
    assign w_we       = {w_wr_hs & r_wb, w_wr_hs & ~r_wb};

    // Bank state next-value: fill side and drain side update different banks.
    always_comb begin
        w_state_nxt[0] = r_state[0];
        w_state_nxt[1] = r_state[1];
        if (w_wr_hs) begin
            w_state_nxt[r_wb] = w_col_last ? BANK_FULL : BANK_FILLING;
        end
        if (w_rd_hs && w_row_last) begin
            w_state_nxt[r_rb] = BANK_EMPTY;
        end
    end

    // State, pointers and counters; clear behaves exactly like reset.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state[0]  <= BANK_EMPTY;
            r_state[1]  <= BANK_EMPTY;
            r_wb        <= 1'b0;
            r_rb        <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_bank_done <= 1'b0;
        end else begin
            r_state[0]  <= w_state_nxt[0];
            r_state[1]  <= w_state_nxt[1];
            r_bank_done <= w_rd_hs & w_row_last;
            if (w_wr_hs) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_wb  <= ~r_wb;
                end else begin
                    r_col <= r_col + c_COLW'(1);
                end
            end
            if (w_rd_hs) begin
                if (w_row_last) begin
                    r_row <= '0;
                    r_rb  <= ~r_rb;
                end else begin
                    r_row <= r_row + c_ROWW'(1);
                end
            end
        end
    end

    redmule_z_drain_scm #(
        .BITW (c_BITW),
        .ROWS (Width),
        .COLS (c_D),
        .COLW (c_COLW),
        .ROWW (c_ROWW)
    ) u_scm (
        .clk_i   (clk_i),
        .we_i    (w_we),
        .wcol_i  (r_col),
        .wdata_i (z_i),
        .rrow_i  (r_row),
        .rdata_o (w_rdata)
    );

    // Output row: columns beyond the tile width, and idle cycles, read as zero
    // so stale storage never leaks onto the stream.
    always_comb begin
        z_o = '0;
        for (int c = 0; c < int'(c_D); c++) begin
            if (z_valid_o && (c < int'(ctrl_i.width))) begin
                z_o[c*c_BITW +: c_BITW] = w_rdata[r_rb][c];
            end
        end
    end

    // Byte enables cover exactly the valid columns.
    always_comb begin
        z_strb_o = '0;
        for (int b = 0; b < int'(c_NBYTE); b++) begin
            z_strb_o[b] = (b < int'(ctrl_i.width) * int'(c_BITW / 8));
        end
    end

    assign flags_o.full      = (r_state[0] == BANK_FULL)  && (r_state[1] == BANK_FULL);
    assign flags_o.empty     = (r_state[0] == BANK_EMPTY) && (r_state[1] == BANK_EMPTY);
    assign flags_o.bank_done = r_bank_done;

endmodule
`default_nettype wire

// File: tb/tb_redmule_z_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_redmule_z_drain
//  Description : Self-checking bench for redmule_z_drain with a tile-queue
//                reference model and directed plus randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_redmule_z_drain;
    import redmule_pkg::*;

    localparam int W    = ARRAY_WIDTH;
    localparam int BITW = 16;
    localparam int D    = 18;
    localparam int DW   = 288;
    localparam int TB   = W * D * BITW;

    logic                      clk;
    logic                      rst_i;
    logic                      clear_i;
    z_drain_ctrl_t             ctrl_i;
    z_drain_flgs_t             flags_o;
    logic [W-1:0][BITW-1:0]    z_i;
    logic                      z_valid_i;
    logic                      z_ready_o;
    logic [DW-1:0]             z_o;
    logic [DW/8-1:0]           z_strb_o;
    logic                      z_valid_o;
    logic                      z_ready_i;

    redmule_z_drain #(
        .DW       (DW),
        .FpFormat (FP16),
        .Width    (W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .ctrl_i    (ctrl_i),
        .flags_o   (flags_o),
        .z_i       (z_i),
        .z_valid_i (z_valid_i),
        .z_ready_o (z_ready_o),
        .z_o       (z_o),
        .z_strb_o  (z_strb_o),
        .z_valid_o (z_valid_o),
        .z_ready_i (z_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of complete tiles -------------
    logic [TB-1:0] m_q [$];
    logic [TB-1:0] m_cur;
    int            m_col = 0;
    int            m_row = 0;
    bit            m_done = 0;
    bit            m_init = 0;
    int            m_wr_cnt = 0;
    bit            m_wr, m_rd;

    always @(posedge clk) begin
        if (rst_i || clear_i) begin
            m_q.delete();
            m_col  = 0;
            m_row  = 0;
            m_done = 0;
            m_init = 1;
        end else if (m_init) begin
            m_wr   = z_valid_i && (m_q.size() < 2);
            m_rd   = z_ready_i && (m_q.size() > 0);
            m_done = 0;
            if (m_rd) begin
                if (m_row == int'(ctrl_i.height) - 1) begin
                    void'(m_q.pop_front());
                    m_row  = 0;
                    m_done = 1;
                end else begin
                    m_row++;
                end
            end
            if (m_wr) begin
                for (int r = 0; r < W; r++) m_cur[(r*D + m_col)*BITW +: BITW] = z_i[r];
                m_wr_cnt++;
                if (m_col == int'(ctrl_i.width) - 1) begin
                    m_q.push_back(m_cur);
                    m_col = 0;
                end else begin
                    m_col++;
                end
            end
        end
    end

    // ---------------- per-cycle comparison against the model ---------------
    logic [DW-1:0]   e_z;
    logic [DW/8-1:0] e_strb;
    logic [TB-1:0]   e_tile;

    always @(negedge clk) begin
        if (m_init) begin
            e_z = '0;
            if (m_q.size() > 0) begin
                e_tile = m_q[0];
                for (int c = 0; c < int'(ctrl_i.width); c++)
                    e_z[c*BITW +: BITW] = e_tile[(m_row*D + c)*BITW +: BITW];
            end
            e_strb = '0;
            for (int b = 0; b < DW/8; b++) e_strb[b] = (b < 2 * int'(ctrl_i.width));
            check("z_valid_o", DW'(z_valid_o),         DW'(m_q.size() > 0));
            check("z_ready_o", DW'(z_ready_o),         DW'(m_q.size() < 2));
            check("z_o",       z_o,                    e_z);
            check("z_strb_o",  DW'(z_strb_o),          DW'(e_strb));
            check("full",      DW'(flags_o.full),      DW'(m_q.size() == 2));
            check("empty",     DW'(flags_o.empty),     DW'(m_q.size() == 0 && m_col == 0));
            check("bank_done", DW'(flags_o.bank_done), DW'(m_done));
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [W-1:0][BITW-1:0] rand_col();
        logic [W-1:0][BITW-1:0] v;
        for (int r = 0; r < W; r++) v[r] = BITW'($urandom);
        return v;
    endfunction

    task automatic set_ctrl(input int w, input int h);
        ctrl_i.width  = 8'(w);
        ctrl_i.height = 8'(h);
    endtask

    task automatic wait_empty(input string name);
        int k;
        k = 0;
        while (!(m_q.size() == 0 && m_col == 0) && k < 200) begin
            step();
            k++;
        end
        check(name, DW'(k < 200), DW'(1));
    endtask

    int n_done, n_val, target, k;

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; set_ctrl(18, W);
        z_valid_i = 1'b0; z_ready_i = 1'b0; z_i = '0;
        step(); step();

        // Reset values, hand-computed
        check("rst_valid", DW'(z_valid_o),         DW'(0));
        check("rst_ready", DW'(z_ready_o),         DW'(1));
        check("rst_empty", DW'(flags_o.empty),     DW'(1));
        check("rst_full",  DW'(flags_o.full),      DW'(0));
        check("rst_done",  DW'(flags_o.bank_done), DW'(0));
        check("rst_z",     z_o,                    DW'(0));
        check("rst_strb",  DW'(z_strb_o),          DW'(36'hF_FFFF_FFFF));
        rst_i = 1'b0;
        step();

        // Single full tile, back-to-back columns
        z_ready_i = 1'b1; z_valid_i = 1'b1;
        for (int i = 0; i < 18; i++) begin
            z_i = rand_col();
            step();
            if (i == 16) check("tile_not_early", DW'(z_valid_o), DW'(0));
        end
        check("tile_first_valid", DW'(z_valid_o), DW'(1));
        z_valid_i = 1'b0;
        n_done = 0;
        for (int i = 0; i < W + 3; i++) begin
            step();
            if (flags_o.bank_done) n_done++;
        end
        check("tile_done_once", DW'(n_done), DW'(1));

        // Partial tile 3x2
        set_ctrl(3, 2);
        z_ready_i = 1'b0; z_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin z_i = rand_col(); step(); end
        z_valid_i = 1'b0;
        check("part_valid",      DW'(z_valid_o),    DW'(1));
        check("part_strb",       DW'(z_strb_o),     DW'(36'h3F));
        check("part_upper_zero", DW'(z_o[287:48]),  DW'(0));
        z_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("part_drained", DW'(flags_o.empty), DW'(1));

        // Backpressure: three 2x2 tiles offered while the stream stalls
        set_ctrl(2, 2);
        z_ready_i = 1'b0; z_valid_i = 1'b1;
        target = m_wr_cnt + 6;
        for (int i = 0; i < 20; i++) begin z_i = rand_col(); step(); end
        check("bp_full",  DW'(flags_o.full), DW'(1));
        check("bp_ready", DW'(z_ready_o),    DW'(0));
        check("bp_valid", DW'(z_valid_o),    DW'(1));
        z_ready_i = 1'b1;
        k = 0;
        while (m_wr_cnt < target && k < 50) begin z_i = rand_col(); step(); k++; end
        check("bp_cols_taken", DW'(m_wr_cnt >= target), DW'(1));
        z_valid_i = 1'b0;
        wait_empty("bp_drain_bound");

        // Overlap: 1x1 tiles streaming continuously
        set_ctrl(1, 1);
        z_valid_i = 1'b1; z_ready_i = 1'b1; n_val = 0;
        for (int i = 0; i < 20; i++) begin
            z_i = rand_col();
            step();
            if (z_valid_o) n_val++;
        end
        check("overlap_no_bubble", DW'(n_val), DW'(20));
        z_valid_i = 1'b0;
        wait_empty("overlap_drain_bound");

        // Reset during drain at row 2
        set_ctrl(2, W);
        z_ready_i = 1'b0; z_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin z_i = rand_col(); step(); end
        z_valid_i = 1'b0; z_ready_i = 1'b1;
        step(); step();
        rst_i = 1'b1;
        step();
        check("mid_rst_valid", DW'(z_valid_o),     DW'(0));
        check("mid_rst_empty", DW'(flags_o.empty), DW'(1));
        rst_i = 1'b0; z_ready_i = 1'b0; z_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin z_i = rand_col(); step(); end
        z_valid_i = 1'b0; z_ready_i = 1'b1;
        wait_empty("mid_rst_drain_bound");

        // Randomized sessions with random handshakes and one soft clear
        for (int s = 0; s < 12; s++) begin
            set_ctrl($urandom_range(1, D), $urandom_range(1, W));
            target = m_wr_cnt + int'($urandom_range(1, 4)) * int'(ctrl_i.width);
            k = 0;
            while (!(m_wr_cnt >= target && m_q.size() == 0 && m_col == 0) && k < 2000) begin
                if (s == 5 && k == 7) begin
                    z_valid_i = 1'b0; clear_i = 1'b1;
                    step();
                    clear_i = 1'b0;
                    target = m_wr_cnt + int'(ctrl_i.width);
                end
                z_valid_i = (m_wr_cnt < target) && ($urandom_range(0, 3) != 0);
                z_ready_i = ($urandom_range(0, 2) != 0);
                z_i = rand_col();
                step();
                k++;
            end
            z_valid_i = 1'b0;
            check("rand_session_bound", DW'(k < 2000), DW'(1));
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
